// File: rtl/event_counter_bank_pkg.sv
// Shared types and helpers for the event counter bank.
// Optional feature macro: EVENT_COUNTER_BANK_OVF_EN (overflow flags / irq).
package event_counter_bank_pkg;

    localparam int CH_MAX    = 64;
    localparam int WIDTH_MAX = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Channel index width; a single-channel bank still needs one bit.
    function automatic int chw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/event_counter_channel.sv
// One event channel: input sampling, rising-edge detect, wrap/saturate
// counter and (with EVENT_COUNTER_BANK_OVF_EN) a sticky overflow flag.
module event_counter_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             evt_i,
    input  logic             en_i,
    input  logic             sat_i,
    input  logic             clr_i,
    input  logic             snap_clr_acc_i,
    output logic [WIDTH-1:0] cnt_o
`ifdef EVENT_COUNTER_BANK_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             evt_q, evt_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             rise;
    logic             at_max;

    // Next count: clear beats snapshot-clear beats increment; an event on the
    // snapshot-clear cycle seeds the fresh count so it is never lost.
    always_comb begin
        evt_d  = evt_i;
        rise   = evt_i & ~evt_q & en_i;
        at_max = (cnt_q == CNT_MAX);
        cnt_d  = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (snap_clr_acc_i) begin
            cnt_d = {{(WIDTH-1){1'b0}}, rise};
        end else if (rise) begin
            if (!at_max)     cnt_d = cnt_q + CNT_ONE;
            else if (!sat_i) cnt_d = '0;
        end
    end

    // Counter and edge-detect state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            evt_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            evt_q <= evt_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifdef EVENT_COUNTER_BANK_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky overflow: a new overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d = (ovf_q & ~(clr_i | snap_clr_acc_i)) | (rise & at_max);
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (!rstn) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

endmodule

// File: rtl/event_counter_bank.sv
// Multi-channel synchronous event counter bank with snapshot shadow
// registers and a valid/ready readout stream, one channel per handshake.
// Optional feature macro: EVENT_COUNTER_BANK_OVF_EN adds ovf_o / irq_o.
module event_counter_bank
    import event_counter_bank_pkg::*;
#(
    parameter int CH    = 8,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CH-1:0]         evt_i,
    input  logic [CH-1:0]         en_i,
    input  logic                  sat_i,
    input  logic                  clr_i,
    input  logic                  snap_i,
    input  logic                  snap_clr_i,
    output logic                  busy_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [chw(CH)-1:0]    rd_chan_o,
    output logic                  rd_last_o
`ifdef EVENT_COUNTER_BANK_OVF_EN
    ,
    output logic [CH-1:0]         ovf_o,
    output logic                  irq_o
`endif
);

    localparam int             CHW      = chw(CH);
    localparam logic [CHW-1:0] LAST_IDX = CHW'(CH - 1);
    localparam logic [CHW-1:0] IDX_ONE  = CHW'(1);

    logic [CH-1:0][WIDTH-1:0] cnt;
    logic [CH-1:0][WIDTH-1:0] shadow_q, shadow_d;
    state_e                   state_q, state_d;
    logic [CHW-1:0]           idx_q, idx_d, idx_nxt;
    logic [WIDTH-1:0]         rd_data_q, rd_data_d;
    logic                     rd_last_q, rd_last_d;
    logic                     snap_acc;
    logic                     snap_clr_acc;

    // A snapshot is only taken from IDLE; requests mid-stream are dropped.
    assign snap_acc     = snap_i & (state_q == IDLE);
    assign snap_clr_acc = snap_acc & snap_clr_i;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        event_counter_channel #(.WIDTH(WIDTH)) u_ch (
            .clk            (clk),
            .rstn           (rstn),
            .evt_i          (evt_i[c]),
            .en_i           (en_i[c]),
            .sat_i          (sat_i),
            .clr_i          (clr_i),
            .snap_clr_acc_i (snap_clr_acc),
            .cnt_o          (cnt[c])
`ifdef EVENT_COUNTER_BANK_OVF_EN
            ,
            .ovf_o          (ovf_o[c])
`endif
        );
    end

`ifdef EVENT_COUNTER_BANK_OVF_EN
    assign irq_o = |ovf_o;
`endif

    // Readout FSM next state. Output data is precomputed here and registered,
    // so rd_ready_i only reaches flop inputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        rd_data_d = rd_data_q;
        rd_last_d = rd_last_q;
        idx_nxt   = idx_q + IDX_ONE;
        unique case (state_q)
            IDLE: begin
                if (snap_i) begin
                    shadow_d  = cnt;
                    state_d   = STREAM;
                    idx_d     = '0;
                    rd_data_d = cnt[0];
                    rd_last_d = (CH == 1);
                end
            end
            STREAM: begin
                if (rd_ready_i) begin
                    if (rd_last_q) begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        rd_data_d = '0;
                        rd_last_d = 1'b0;
                    end else begin
                        idx_d     = idx_nxt;
                        rd_data_d = shadow_q[idx_nxt];
                        rd_last_d = (idx_nxt == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM, shadow and readout registers; reset may land mid-stream.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            rd_data_q <= '0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            rd_data_q <= rd_data_d;
            rd_last_q <= rd_last_d;
        end
    end

    assign busy_o     = (state_q == STREAM);
    assign rd_valid_o = (state_q == STREAM);
    assign rd_data_o  = rd_data_q;
    assign rd_chan_o  = idx_q;
    assign rd_last_o  = rd_last_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Self-checking bench for event_counter_bank (CH=4, WIDTH=4): a table of
// pulse scenarios, hand-written corner sequences and a randomized run, all
// shadowed cycle-by-cycle by a behavioural model.
module tb_event_counter_bank;

    localparam int CH    = 4;
    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic [CH-1:0]    evt, en;
    logic             sat, clr, snap, snap_clr, ready;
    logic             busy_o, rd_valid_o, rd_last_o;
    logic [WIDTH-1:0] rd_data_o;
    logic [1:0]       rd_chan_o;
`ifdef EVENT_COUNTER_BANK_OVF_EN
    logic [CH-1:0]    ovf_o;
    logic             irq_o;
`endif

    event_counter_bank #(.CH(CH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .evt_i      (evt),
        .en_i       (en),
        .sat_i      (sat),
        .clr_i      (clr),
        .snap_i     (snap),
        .snap_clr_i (snap_clr),
        .busy_o     (busy_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (ready),
        .rd_data_o  (rd_data_o),
        .rd_chan_o  (rd_chan_o),
        .rd_last_o  (rd_last_o)
`ifdef EVENT_COUNTER_BANK_OVF_EN
        ,
        .ovf_o      (ovf_o),
        .irq_o      (irq_o)
`endif
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int chan; int data; } word_t;
    int    m_cnt[CH];
    bit    m_prev[CH];
    bit    m_ovf[CH];
    word_t m_q[$];
    bit    m_fresh;
    int    rv[CH];

    function automatic void model_edge();
        bit    acc, rise, hit;
        word_t w;
        if (!rstn) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = 0; m_prev[c] = 0; m_ovf[c] = 0;
            end
            m_q.delete();
            m_fresh = 1;
            return;
        end
        acc = snap && (m_q.size() == 0);
        if (m_q.size() > 0 && ready) void'(m_q.pop_front());
        if (acc) begin
            for (int c = 0; c < CH; c++) begin
                w.chan = c; w.data = m_cnt[c];
                m_q.push_back(w);
            end
            m_fresh = 0;
        end
        for (int c = 0; c < CH; c++) begin
            rise = evt[c] && !m_prev[c] && en[c];
            hit  = rise && (m_cnt[c] == MAXV);
            if (clr)                  m_cnt[c] = 0;
            else if (acc && snap_clr) m_cnt[c] = rise ? 1 : 0;
            else if (rise)            m_cnt[c] = (m_cnt[c] == MAXV) ? (sat ? MAXV : 0) : m_cnt[c] + 1;
            if (clr || (acc && snap_clr)) m_ovf[c] = 0;
            if (hit)                      m_ovf[c] = 1;
            m_prev[c] = evt[c];
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit valid;
        valid = (m_q.size() > 0);
        chk("rd_valid", rd_valid_o, valid);
        chk("busy", busy_o, valid);
        if (valid) begin
            chk("rd_chan", rd_chan_o, m_q[0].chan);
            chk("rd_data", rd_data_o, m_q[0].data);
            chk("rd_last", rd_last_o, m_q[0].chan == CH - 1);
        end else if (m_fresh) begin
            chk("idle_data", rd_data_o, 0);
            chk("idle_chan", rd_chan_o, 0);
            chk("idle_last", rd_last_o, 0);
        end
`ifdef EVENT_COUNTER_BANK_OVF_EN
        begin
            logic [CH-1:0] eo;
            for (int c = 0; c < CH; c++) eo[c] = m_ovf[c];
            chk("ovf", ovf_o, eo);
            chk("irq", irq_o, |eo);
        end
`endif
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            evt[c] = 1'b1; tick();
            evt[c] = 1'b0; tick();
        end
    endtask

    // Stream CH words out with ready held high, capturing them into rv.
    task automatic read_stream();
        ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            rv[i] = int'(rd_data_o);
            tick();
        end
        ready = 1'b0;
    endtask

    task automatic snap_read();
        snap = 1'b1; tick();
        snap = 1'b0;
        read_stream();
    endtask

    task automatic do_clr();
        clr = 1'b1; tick();
        clr = 1'b0; tick();
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int ch; int npulse; bit sat; bit en; int exp_cnt; bit exp_ovf;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2, 17, 1'b0, 1'b1,  1, 1'b1};  // wrap past max
        tbl[1] = '{0, 20, 1'b1, 1'b1, 15, 1'b1};  // saturate
        tbl[2] = '{1,  5, 1'b0, 1'b1,  5, 1'b0};
        tbl[3] = '{3, 16, 1'b0, 1'b1,  0, 1'b1};  // exactly one wrap
        tbl[4] = '{3, 16, 1'b1, 1'b1, 15, 1'b1};
        tbl[5] = '{3,  5, 1'b0, 1'b0,  0, 1'b0};  // enable low
        tbl[6] = '{0, 15, 1'b1, 1'b1, 15, 1'b0};  // reaches max, no overflow

        rstn = 1'b0; evt = '0; en = '1; sat = 1'b0; clr = 1'b0;
        snap = 1'b0; snap_clr = 1'b0; ready = 1'b0;
        tick(); tick();
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", rd_data_o, 0);
        rstn = 1'b1;
        tick();

        // Table-driven pulse scenarios.
        foreach (tbl[i]) begin
            do_clr();
            sat = tbl[i].sat;
            en = '1;
            en[tbl[i].ch] = tbl[i].en;
            pulse(tbl[i].ch, tbl[i].npulse);
            snap_read();
            for (int c = 0; c < CH; c++)
                chk($sformatf("tbl%0d_ch%0d", i, c), rv[c], (c == tbl[i].ch) ? tbl[i].exp_cnt : 0);
`ifdef EVENT_COUNTER_BANK_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), ovf_o[tbl[i].ch], tbl[i].exp_ovf);
`endif
            en = '1;
        end

        // Saturate then clear: flags drop and the next snapshot reads zero.
        do_clr();
        sat = 1'b1;
        pulse(0, 20);
`ifdef EVENT_COUNTER_BANK_OVF_EN
        chk("sat_ovf_set", ovf_o, 4'b0001);
`endif
        do_clr();
`ifdef EVENT_COUNTER_BANK_OVF_EN
        chk("clr_ovf", ovf_o, 0);
`endif
        snap_read();
        chk("clr_snap_ch0", rv[0], 0);
        sat = 1'b0;

        // Level input counts once.
        do_clr();
        evt[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        evt[1] = 1'b0; tick();
        snap_read();
        chk("level_ch1", rv[1], 1);

        // Snapshot collides with a rising edge while clearing.
        do_clr();
        pulse(1, 5);
        evt[1] = 1'b1; snap = 1'b1; snap_clr = 1'b1;
        tick();
        evt[1] = 1'b0; snap = 1'b0; snap_clr = 1'b0;
        read_stream();
        chk("coll_ch1", rv[1], 5);
        snap_read();
        chk("coll_next_ch1", rv[1], 1);

        // Backpressure with ready pattern 1,0,0 and snap requests mid-stream.
        do_clr();
        for (int c = 0; c < CH; c++) pulse(c, c + 1);
        snap = 1'b1; tick(); snap = 1'b0;
        begin
            int nhs = 0;
            logic [WIDTH-1:0] pdata;
            logic [1:0] pchan;
            bit stalled = 0;
            for (int k = 0; k < 60 && nhs < CH; k++) begin
                ready = (k % 3 == 0);
                snap  = (nhs < 2);
                if (stalled) begin
                    chk("bp_stable_data", rd_data_o, pdata);
                    chk("bp_stable_chan", rd_chan_o, pchan);
                end
                if (rd_valid_o && ready) begin
                    chk("bp_order", rd_chan_o, nhs);
                    chk("bp_data", rd_data_o, nhs + 1);
                    chk("bp_last", rd_last_o, nhs == CH - 1);
                    nhs++;
                end
                stalled = rd_valid_o && !ready;
                pdata = rd_data_o; pchan = rd_chan_o;
                tick();
            end
            snap = 1'b0; ready = 1'b0;
            chk("bp_handshakes", nhs, CH);
            chk("bp_idle_after", rd_valid_o, 0);
        end

        // Reset in the middle of a stream at index 2.
        pulse(2, 3);
        snap = 1'b1; tick(); snap = 1'b0;
        ready = 1'b1; tick(); tick(); ready = 1'b0;
        chk("mid_idx", rd_chan_o, 2);
        rstn = 1'b0; tick();
        chk("mr_valid", rd_valid_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_data", rd_data_o, 0);
        chk("mr_chan", rd_chan_o, 0);
        chk("mr_last", rd_last_o, 0);
        rstn = 1'b1; tick();
        snap_read();
        for (int c = 0; c < CH; c++) chk($sformatf("mr_snap_ch%0d", c), rv[c], 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            evt      = CH'($urandom);
            en       = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
            sat      = ($urandom_range(0, 63) == 0) ? ~sat : sat;
            clr      = ($urandom_range(0, 40) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            snap_clr = $urandom_range(0, 1);
            ready    = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/event_counter_bank.md
# event_counter_bank

Parametrised multi-channel event counter: counts rising edges on `CH` independent event inputs in `WIDTH`-bit counters, fully synchronous to one clock. Counting runs in wrap or saturate mode. A snapshot request freezes all counts into shadow registers, which then stream out one channel per handshake over a valid/ready port. The block is the general replacement for single-channel, input-clocked bit counters: events are sampled as data, not used as clocks.

## Interface
- `CH`, 8, number of event channels (1..64)
- `WIDTH`, 8, counter width per channel (2..32)
- `clk` in 1: sole clock, rising edge
- `rstn` in 1: synchronous active-low reset
- `evt_i` in CH: event inputs, already synchronous to `clk`
- `en_i` in CH: per-channel count enable
- `sat_i` in 1: 1 = saturate at max, 0 = wrap to 0
- `clr_i` in 1: synchronous clear of live counters and overflow flags
- `snap_i` in 1: snapshot request, single-cycle or level
- `snap_clr_i` in 1: sampled with `snap_i`; 1 = clear live counters at snapshot
- `busy_o` out 1: readout stream in progress
- `rd_valid_o` out 1: readout word valid
- `rd_ready_i` in 1: readout consumer ready
- `rd_data_o` out WIDTH: shadow count of channel `rd_chan_o`
- `rd_chan_o` out CHW: channel index, CHW = max(1, clog2(CH))
- `rd_last_o` out 1: current word is channel CH-1
- `ovf_o` out CH: sticky per-channel overflow (macro only)
- `irq_o` out 1: OR of `ovf_o` (macro only)

## Operation
- Edge detect per channel: `evt_q <= evt_i`. `rise = evt_i & ~evt_q & en_i`. `evt_q` updates regardless of `en_i`.
- Live counter update, priority high to low:
  - `clr_i`: counter = 0.
  - Snapshot accepted with `snap_clr_i=1`: counter = `rise` (0 or 1). The event in the snapshot cycle is never lost.
  - `rise`, counter < 2^WIDTH-1: counter + 1.
  - `rise` at max: `sat_i=0` gives 0, `sat_i=1` holds max. Both cases set overflow.
- FSM `IDLE` / `STREAM`:
  - In `IDLE`, `snap_i=1` is accepted. At that edge, shadow[c] = the live counter value before that cycle's increment, and the FSM enters `STREAM` with index 0.
  - In `STREAM`: `rd_valid_o=1`, `busy_o=1`, `rd_data_o=shadow[idx]`, `rd_chan_o=idx`, `rd_last_o=(idx==CH-1)`.
  - On `rd_valid_o & rd_ready_i`, idx increments. The handshake with `rd_last_o=1` returns the FSM to `IDLE`.
  - `snap_i` during `STREAM` is ignored, with no queueing. Counting continues during `STREAM`.
  - Outputs stay stable while `rd_valid_o & ~rd_ready_i`.
- `clr_i` does not touch shadow registers or the FSM.
- Reset (`rstn=0` at an edge) is allowed mid-stream:
  - All counters, shadows, `evt_q`, and flags become 0.
  - FSM returns to `IDLE`, index 0.
  - Outputs: `rd_valid_o=0`, `busy_o=0`, `rd_data_o=0`, `rd_chan_o=0`, `rd_last_o=0`, `ovf_o=0`, `irq_o=0`.

## Timing
- Event sampled high (previous sample low) at edge k: count visible after edge k.
- `snap_i` at edge k: `rd_valid_o` is 1 from edge k onward, showing channel 0.
- Zero-wait readout with `rd_ready_i` held 1: CH cycles in `STREAM`. `snap_i` is accepted again at the edge after the last handshake, so the minimum period is CH+1 cycles.
- An event high for many cycles counts once. Toggling every cycle gives at most one count per two cycles.
- `rd_*` outputs are registered; `rd_ready_i` has no combinational path to any output.

## Configuration
- Macro: `EVENT_COUNTER_BANK_OVF_EN`.
- Defined:
  - `ovf_o` and `irq_o` exist.
  - `ovf_o[c]` sets on the overflow event.
  - It clears on `clr_i`, or on an accepted snapshot with `snap_clr_i=1`.
  - Set wins over a clear in the same cycle.
- Undefined: both ports and all flag logic are absent. Counting behaviour is unchanged.

## Structure
- `event_counter_bank_pkg` holds:
  - the FSM state enum (`IDLE`, `STREAM`);
  - a `chw(CH)` width function;
  - the limit constants `CH_MAX=64` and `WIDTH_MAX=32`.
- Sub-module `event_counter_channel` holds one channel: `evt_q`, edge detect, counter, saturate/wrap, overflow flag. It is instantiated CH times with a generate loop.
- The top holds the shadow array, FSM, and readout mux.

## Test plan
- Wrap (CH=4, WIDTH=4, `sat_i=0`): 17 pulses on ch2. The snapshot reads ch2=1 and the others 0; `ovf_o=4'b0100`, `irq_o=1`.
- Saturate (`sat_i=1`): 20 pulses on ch0. Readout ch0=15; `ovf_o[0]=1`. `clr_i` then gives `ovf_o=0` and a next snapshot of 0.
- Level and enable: `evt_i[1]` held high 10 cycles gives count 1. Pulses on ch3 with `en_i[3]=0` give count 0.
- Snapshot collision: ch1 count 5, with a rising edge on the `snap_i` cycle and `snap_clr_i=1`. Readout ch1=5; the next snapshot reads 1.
- Backpressure: `rd_ready_i` toggled 1,0,0,1,... Each channel is read exactly once in order 0..CH-1, data is stable while stalled, `rd_last_o` is asserted only at CH-1, and `snap_i` mid-stream is ignored.
- Reset mid-stream at idx 2: all outputs are 0 the next cycle, and a fresh snapshot reads all zeros.
